coin_collector: RTL and testbench
=================================

Name: coin_collector

Overview:
- Front-end stage of the vending path. Accepts coin events, accumulates a 3-bit credit, and hands that credit to the food-selling controller through a valid/ack handshake.
- The handed-off credit drives the controller's money input.
- Also handles cancel (full refund) and overflow rejection.
- Auto-commits the credit after an inactivity timeout, so a customer who walks away does not stall the machine.

Parameters:
- MAX_CREDIT, 7, highest credit accepted; must be <= 7 (3-bit money path).
- IDLE_TIMEOUT, 16, consecutive cycles with no accepted coin in COLLECT before auto-commit; must be >= 2.
- TMR_W, 5, width of the inactivity counter; must satisfy 2^TMR_W > IDLE_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- coin_valid  input  1  one-cycle strobe: a coin is present this cycle.
- coin_code  input  2  01=1 unit, 10=2 units, 11=4 units, 00=slug/unknown.
- confirm  input  1  customer finishes inserting; level, sampled each cycle.
- cancel  input  1  customer requests refund; level, sampled each cycle.
- money_ack  input  1  downstream has taken money this cycle.
- money  output  3  credit offered downstream; valid only while money_valid=1.
- money_valid  output  1  credit offer pending.
- refund_valid  output  1  one-cycle pulse: return refund_amount to customer.
- refund_amount  output  3  amount to return; meaningful only with refund_valid.
- coin_reject  output  1  one-cycle pulse: last coin returned, not credited.
- credit  output  3  running credit, for display.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1), all outputs and internal state cleared:
  - state=IDLE; credit, money, money_valid, refund_valid, refund_amount, coin_reject, busy and the timer all 0.
  - Reset mid-transaction discards credit; no refund pulse is issued.
- All outputs are registered.
- Coin valuation: value = 1, 2 or 4 for codes 01, 10, 11.
  - A coin is accepted iff the state is IDLE or COLLECT, the code is not 00, and credit+value <= MAX_CREDIT.
  - Sum is computed 4 bits wide, so no wrap-around.
  - Accepted: credit += value at that edge.
  - Otherwise: coin_reject=1 for exactly the next cycle; credit unchanged.
- IDLE:
  - Accepted coin -> credit=value, timer=0, go to COLLECT.
  - confirm/cancel with zero credit are ignored.
- COLLECT:
  - Timer increments each cycle; it clears on every accepted coin.
  - Priority, evaluated on one edge:
    1. cancel -> REFUND. A coin accepted in the same cycle is included in the refund.
    2. confirm -> OFFER with credit including any same-cycle accepted coin.
    3. timer == IDLE_TIMEOUT-1 with no coin this cycle -> OFFER (auto-commit).
    4. Otherwise stay.
- Entering OFFER: money <= final credit and money_valid <= 1 on the same edge.
  - Latency: confirm sampled at edge N gives money_valid=1 after edge N.
- OFFER:
  - money and money_valid held stable until money_ack=1 is sampled.
  - On that edge: money_valid <= 0, credit <= 0, go to IDLE.
  - Coins are rejected (coin_reject pulse); cancel and confirm are ignored.
  - money_ack outside OFFER is ignored.
- REFUND, lasts exactly one cycle:
  - refund_valid=1 and refund_amount=credit during that cycle.
  - Next edge: refund_valid <= 0, credit <= 0, go to IDLE.
  - Coins arriving in REFUND are rejected.
- busy=1 in COLLECT, OFFER and REFUND.
- Credit can never exceed MAX_CREDIT. A coin that would overflow is rejected even when the current credit < MAX_CREDIT (e.g. credit 5 + coin 4 -> reject).

Test Plan:
- Reset, then coins 01, 10, 11 on separate cycles, then confirm -> credit 1, 3, 7; money_valid=1 with money=7 the cycle after confirm; hold money_ack=0 for 5 cycles -> money stays 7; ack -> money_valid=0, credit=0, busy=0.
- Coins 11, then 10, then 10 -> credit 4, 6; third coin gives a one-cycle coin_reject pulse with credit still 6; a 00 slug in IDLE -> coin_reject pulse, state stays IDLE.
- Coin 10 then cancel; also coin 01 and cancel in the same cycle after credit 2 -> refund_valid single pulse with refund_amount=2 in the first case and 3 in the second; then IDLE with credit 0.
- Coin 01 then idle: no coin for IDLE_TIMEOUT=16 cycles -> money_valid rises with money=1. A second coin at cycle 10 restarts the count, so auto-commit happens 16 cycles after that coin.
- confirm and cancel asserted together with credit 4 -> refund pulse of 4, money_valid never rises. Coin during OFFER -> reject pulse, money unchanged.
- rst asserted during OFFER (money=5) -> all outputs 0 immediately, with no refund pulse; after release, a coin 01 starts a fresh credit of 1.

Source files
------------

// File: rtl/coin_collector.sv
// Coin front-end for the vending path: accumulates a 3-bit credit from coin strobes and
// hands it downstream over a valid/ack handshake, with cancel refund and idle auto-commit.
module coin_collector #(
   parameter int unsigned MAX_CREDIT   = 7,
   parameter int unsigned IDLE_TIMEOUT = 16,
   parameter int unsigned TMR_W        = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_valid,
   input  logic [1:0] coin_code,
   input  logic       confirm,
   input  logic       cancel,
   input  logic       money_ack,
   output logic [2:0] money,
   output logic       money_valid,
   output logic       refund_valid,
   output logic [2:0] refund_amount,
   output logic       coin_reject,
   output logic [2:0] credit,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, COLLECT, OFFER, REFUND} state_t;

   state_t             state, state_d;
   logic [TMR_W-1:0]   timer, timer_d;
   logic [2:0]         credit_d, money_d, refund_amount_d, new_credit;
   logic               money_valid_d, refund_valid_d, coin_reject_d, busy_d;
   logic [3:0]         coin_value, sum;
   logic               accept;

   // Coin valuation and acceptance; sum kept 4 bits wide so an overflow cannot wrap.
   always_comb begin
      coin_value = 4'd0;
      case (coin_code)
         2'b01:   coin_value = 4'd1;
         2'b10:   coin_value = 4'd2;
         2'b11:   coin_value = 4'd4;
         default: coin_value = 4'd0;
      endcase
      sum        = {1'b0, credit} + coin_value;
      accept     = coin_valid && (coin_code != 2'b00) &&
                   ((state == IDLE) || (state == COLLECT)) &&
                   (sum <= 4'(MAX_CREDIT));
      new_credit = accept ? sum[2:0] : credit;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d         = state;
      timer_d         = timer;
      credit_d        = credit;
      money_d         = money;
      money_valid_d   = money_valid;
      refund_valid_d  = 1'b0;
      refund_amount_d = refund_amount;
      coin_reject_d   = coin_valid && !accept;

      case (state)
         IDLE: begin
            if (accept) begin
               credit_d = sum[2:0];
               timer_d  = '0;
               state_d  = COLLECT;
            end
         end
         COLLECT: begin
            credit_d = new_credit;
            timer_d  = accept ? '0 : timer + TMR_W'(1);
            if (cancel) begin
               state_d         = REFUND;
               refund_valid_d  = 1'b1;
               refund_amount_d = new_credit;
            end else if (confirm ||
                         (!accept && (timer == TMR_W'(IDLE_TIMEOUT - 1)))) begin
               state_d       = OFFER;
               money_d       = new_credit;
               money_valid_d = 1'b1;
            end
         end
         OFFER: begin
            if (money_ack) begin
               money_valid_d = 1'b0;
               credit_d      = 3'd0;
               state_d       = IDLE;
            end
         end
         REFUND: begin
            credit_d = 3'd0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         timer         <= '0;
         credit        <= 3'd0;
         money         <= 3'd0;
         money_valid   <= 1'b0;
         refund_valid  <= 1'b0;
         refund_amount <= 3'd0;
         coin_reject   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_d;
         timer         <= timer_d;
         credit        <= credit_d;
         money         <= money_d;
         money_valid   <= money_valid_d;
         refund_valid  <= refund_valid_d;
         refund_amount <= refund_amount_d;
         coin_reject   <= coin_reject_d;
         busy          <= busy_d;
      end
   end

endmodule

// File: tb/tb_coin_collector.sv
// Directed bench for coin_collector: hand-computed credit, offer, refund, reject and timeout values.
module tb_coin_collector;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid, confirm, cancel, money_ack;
   logic [1:0] coin_code;
   logic [2:0] money, refund_amount, credit;
   logic       money_valid, refund_valid, coin_reject, busy;

   int errors = 0;
   int checks = 0;

   coin_collector dut (
      .clk           (clk),
      .rst           (rst),
      .coin_valid    (coin_valid),
      .coin_code     (coin_code),
      .confirm       (confirm),
      .cancel        (cancel),
      .money_ack     (money_ack),
      .money         (money),
      .money_valid   (money_valid),
      .refund_valid  (refund_valid),
      .refund_amount (refund_amount),
      .coin_reject   (coin_reject),
      .credit        (credit),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample just after the edge.
   task automatic tick(input logic cv, input logic [1:0] cc, input logic cf,
                       input logic cn, input logic ak);
      coin_valid = cv;
      coin_code  = cc;
      confirm    = cf;
      cancel     = cn;
      money_ack  = ak;
      @(posedge clk);
      #1;
      coin_valid = 1'b0;
      coin_code  = 2'b00;
      confirm    = 1'b0;
      cancel     = 1'b0;
      money_ack  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 2'b00, 0, 0, 0);
   endtask

   task automatic coin(input logic [1:0] cc);
      tick(1, cc, 0, 0, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".money"},        int'(money), 0);
      check({tag, ".money_valid"},  int'(money_valid), 0);
      check({tag, ".refund_valid"}, int'(refund_valid), 0);
      check({tag, ".refund_amt"},   int'(refund_amount), 0);
      check({tag, ".coin_reject"},  int'(coin_reject), 0);
      check({tag, ".credit"},       int'(credit), 0);
      check({tag, ".busy"},         int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1;
      coin_valid = 1'b0; coin_code = 2'b00; confirm = 1'b0; cancel = 1'b0; money_ack = 1'b0;
      #12;
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic accumulate, confirm, held offer, ack
      coin(2'b01); check("t1.credit1", int'(credit), 1); check("t1.busy", int'(busy), 1);
      coin(2'b10); check("t1.credit3", int'(credit), 3);
      coin(2'b11); check("t1.credit7", int'(credit), 7);
      tick(0, 2'b00, 1, 0, 0);
      check("t1.mv", int'(money_valid), 1); check("t1.money", int'(money), 7);
      idle(5);
      check("t1.hold_mv", int'(money_valid), 1); check("t1.hold_money", int'(money), 7);
      tick(0, 2'b00, 0, 0, 1);
      check("t1.ack_mv", int'(money_valid), 0); check("t1.ack_credit", int'(credit), 0);
      check("t1.ack_busy", int'(busy), 0);

      // Overflow reject and slug reject
      coin(2'b11); check("t2.credit4", int'(credit), 4);
      coin(2'b10); check("t2.credit6", int'(credit), 6); check("t2.norej", int'(coin_reject), 0);
      coin(2'b10); check("t2.rej", int'(coin_reject), 1); check("t2.credit_kept", int'(credit), 6);
      tick(0, 2'b00, 0, 1, 0);
      check("t2.rej_end", int'(coin_reject), 0);
      check("t2.refund", int'(refund_valid), 1); check("t2.refund_amt", int'(refund_amount), 6);
      idle(1);
      coin(2'b00); check("t2.slug_rej", int'(coin_reject), 1); check("t2.slug_busy", int'(busy), 0);
      check("t2.slug_credit", int'(credit), 0);
      idle(1); check("t2.slug_rej_end", int'(coin_reject), 0);

      // Cancel refunds
      coin(2'b10);
      tick(0, 2'b00, 0, 1, 0);
      check("t3.rv", int'(refund_valid), 1); check("t3.amt", int'(refund_amount), 2);
      idle(1);
      check("t3.rv_end", int'(refund_valid), 0); check("t3.credit0", int'(credit), 0);
      check("t3.busy0", int'(busy), 0);
      coin(2'b10);
      tick(1, 2'b01, 0, 1, 0);
      check("t3.rv2", int'(refund_valid), 1); check("t3.amt2", int'(refund_amount), 3);
      idle(1);
      check("t3.rv2_end", int'(refund_valid), 0); check("t3.credit0b", int'(credit), 0);

      // Idle auto-commit
      coin(2'b01);
      idle(15); check("t4.not_yet", int'(money_valid), 0);
      idle(1);  check("t4.auto_mv", int'(money_valid), 1); check("t4.auto_money", int'(money), 1);
      tick(0, 2'b00, 0, 0, 1);
      coin(2'b01);
      idle(9);
      coin(2'b01); check("t4.credit2", int'(credit), 2);
      idle(15); check("t4.restart_not_yet", int'(money_valid), 0);
      idle(1);  check("t4.restart_mv", int'(money_valid), 1); check("t4.restart_money", int'(money), 2);
      tick(0, 2'b00, 0, 0, 1);
      check("t4.ack_busy", int'(busy), 0);

      // Cancel wins over confirm
      coin(2'b11);
      tick(0, 2'b00, 1, 1, 0);
      check("t5.rv", int'(refund_valid), 1); check("t5.amt", int'(refund_amount), 4);
      check("t5.mv", int'(money_valid), 0);
      idle(1); check("t5.mv_after", int'(money_valid), 0); check("t5.credit0", int'(credit), 0);

      // Coin during offer, then reset mid-offer
      coin(2'b01); coin(2'b11);
      tick(0, 2'b00, 1, 0, 0);
      check("t6.money5", int'(money), 5);
      coin(2'b01);
      check("t6.offer_rej", int'(coin_reject), 1); check("t6.money_kept", int'(money), 5);
      check("t6.credit_kept", int'(credit), 5); check("t6.mv_kept", int'(money_valid), 1);
      #2; rst = 1'b1; #1;
      check_all_zero("t6.rst");
      @(posedge clk); #1;
      check("t6.rst_no_refund", int'(refund_valid), 0);
      rst = 1'b0;
      coin(2'b01); check("t6.fresh_credit", int'(credit), 1); check("t6.fresh_busy", int'(busy), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
